alu_seq: RTL
============

# alu_seq

Execution-stage arithmetic unit that consumes the 3-bit operation select produced by the ALU control decoder and computes the result on two WIDTH-bit operands. Logic/add/sub/compare operations complete in one cycle. MUL and DIV run on an iterative shift unit taking WIDTH cycles. A start/busy/done handshake lets the surrounding control stall while a long operation is in flight.

## Interface
- WIDTH, 32, operand and result width (≥ 4).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- sel  in  3  operation select: 000 NOP, 001 AND, 010 OR, 011 SUB, 100 MUL, 101 DIV, 110 ADD, 111 SLT.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- result  out  WIDTH  registered result; holds until the next completion.
- zero  out  1  result == 0, derived from the registered result.
- done  out  1  one-cycle completion pulse; result is valid in the same cycle.
- busy  out  1  high whenever state ≠ IDLE.
- div_by_zero  out  1  registered flag, updated at every completion.

## Operation
- States:
  - IDLE
  - MUL: iterate
  - DIV: iterate
  - DONE: assert done
- IDLE with start=1:
  - Capture sel, a and b.
  - sel=100 → MUL.
  - sel=101 with b≠0 → DIV.
  - Every other sel, and DIV with b=0 → DONE, with result computed in the same edge.
- MUL:
  - Unsigned shift-add, one multiplier bit per cycle.
  - Iteration counter runs 0..WIDTH-1; after WIDTH iterations → DONE.
  - result = low WIDTH bits of the product.
- DIV:
  - Unsigned restoring division, one quotient bit per cycle, WIDTH iterations → DONE.
  - result = quotient; the remainder is discarded.
- DIV with b=0: result = all ones, div_by_zero=1.
- Every other completion clears div_by_zero.
- Single-cycle operations:
  - AND, OR: bitwise.
  - ADD, SUB: modulo 2^WIDTH; no overflow flag.
  - SLT: signed compare; result = 1 if $signed(a) < $signed(b), else 0.
  - NOP: result = 0.
- DONE: done=1 for exactly one cycle, then → IDLE.
- start while busy=1 is ignored; there is no queueing. Upstream must hold or re-issue the request.
- Operands are captured at acceptance, so changes on a, b or sel while busy have no effect.
- Reset values: state IDLE, result 0, zero 1, done 0, busy 0, div_by_zero 0, counter 0.
- rst asserted mid-operation aborts it immediately: no done pulse, and result returns to 0.

## Timing
- Request accepted at edge k:
  - Single-cycle operation or DIV-by-zero: done=1 and result valid during cycle k+1; busy=1 during cycle k+1.
  - MUL or DIV: busy=1 during cycles k+1..k+WIDTH+1; done=1 during cycle k+WIDTH+1 (latency WIDTH+1).
- The earliest next acceptance is the edge ending the DONE cycle.
  - Single-cycle throughput: one operation per 2 cycles.
  - MUL/DIV throughput: one operation per WIDTH+2 cycles.
- done and busy are registered outputs, not combinational from start.

## Structure
- Shared package alu_pkg:
  - sel encoding localparams (OP_NOP … OP_SLT), also used by the ALU control decoder.
  - state enum (IDLE, MUL, DIV, DONE).
- One sub-module, alu_muldiv:
  - Holds the iterative accumulator, shift registers and counter.
  - Ports: clk, rst, load, is_div, a, b, step_en, last, product/quotient.
  - alu_seq keeps the FSM, the single-cycle datapath and the output registers.

## Test plan
- After reset with no start: result=0, zero=1, busy=0, done=0, div_by_zero=0.
- ADD 0xFFFF_FFFF + 1, then SUB 5 − 7:
  - ADD: done in cycle k+1, result=0, zero=1.
  - SUB: result=0xFFFF_FFFE.
- MUL 7 × 6: busy for 33 cycles, done in cycle k+33, result=42. MUL 0x0001_0000 × 0x0001_0000 gives result=0, zero=1.
- DIV:
  - 100 / 7: done at k+33, result=14, div_by_zero=0.
  - 9 / 0: done at k+1, result=0xFFFF_FFFF, div_by_zero=1.
- SLT with a=0xFFFF_FFFF, b=1: result=1. With the operands swapped: result=0. AND 0xF0F0 & 0x0FF0 = 0x00F0.
- Start MUL; pulse start=1 with sel=110 at cycle k+5 (ignored); assert rst at cycle k+10:
  - The ignored request produces no extra done.
  - After rst: no done pulse, all outputs at reset values.
  - A following ADD 2+3 completes normally with result=5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the execution-stage ALU: operation selects and FSM states.
package alu_pkg;

  // Operation select encoding, shared with the ALU control decoder
  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_ADD = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per step.
// res is the value the accumulator (MUL) or quotient (DIV) holds after the
// current step, so the caller can register it on the final step's edge.
module alu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step_en,
  output logic             last,
  output logic [WIDTH-1:0] res
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  // acc: product accumulator or partial remainder
  // opa: multiplier (shifts right) or dividend/quotient (shifts left)
  // opb: multiplicand (shifts left) or divisor (fixed)
  logic [WIDTH-1:0] acc, opa, opb;
  logic             mode_div;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] mul_acc_nxt, rem_nxt, quo_nxt;
  logic [WIDTH:0]   rem_sh, diff;
  logic             q_bit;

  assign last = (cnt == CNT_LAST);

  // Next-step values for both datapaths; mode_div picks the visible result
  always_comb begin
    mul_acc_nxt = opa[0] ? acc + opb : acc;
    rem_sh      = {acc, opa[WIDTH-1]};
    diff        = rem_sh - {1'b0, opb};
    q_bit       = ~diff[WIDTH];
    rem_nxt     = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nxt     = {opa[WIDTH-2:0], q_bit};
    res         = mode_div ? quo_nxt : mul_acc_nxt;
  end

  // Operand load and per-step iteration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      opa      <= '0;
      opb      <= '0;
      mode_div <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      acc      <= '0;
      opa      <= a;
      opb      <= b;
      mode_div <= is_div;
      cnt      <= '0;
    end else if (step_en) begin
      if (mode_div) begin
        acc <= rem_nxt;
        opa <= quo_nxt;
      end else begin
        acc <= mul_acc_nxt;
        opa <= opa >> 1;
        opb <= opb << 1;
      end
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Execution-stage ALU: single-cycle logic/add/sub/compare, iterative MUL/DIV,
// with a start/busy/done handshake.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  state_t           state;
  logic             md_load, md_is_div, md_step, md_last;
  logic             b_is_zero;
  logic [WIDTH-1:0] md_res, single_res;

  assign zero      = (result == '0);
  assign b_is_zero = (b == '0);
  assign md_is_div = (sel == OP_DIV);
  assign md_load   = (state == IDLE) && start &&
                     ((sel == OP_MUL) || ((sel == OP_DIV) && !b_is_zero));
  assign md_step   = (state == MUL) || (state == DIV);

  // Single-cycle result; DIV only reaches here with a zero divisor
  always_comb begin
    single_res = '0;
    case (sel)
      OP_AND:  single_res = a & b;
      OP_OR:   single_res = a | b;
      OP_SUB:  single_res = a - b;
      OP_ADD:  single_res = a + b;
      OP_SLT:  single_res[0] = ($signed(a) < $signed(b));
      OP_DIV:  single_res = '1;
      default: single_res = '0;
    endcase
  end

  alu_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .load    (md_load),
    .is_div  (md_is_div),
    .a       (a),
    .b       (b),
    .step_en (md_step),
    .last    (md_last),
    .res     (md_res)
  );

  // Control FSM with registered result, flags and handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      result      <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (sel == OP_MUL) begin
              state <= MUL;
            end else if ((sel == OP_DIV) && !b_is_zero) begin
              state <= DIV;
            end else begin
              state       <= DONE;
              done        <= 1'b1;
              result      <= single_res;
              div_by_zero <= (sel == OP_DIV);
            end
          end
        end
        MUL, DIV: begin
          if (md_last) begin
            state       <= DONE;
            done        <= 1'b1;
            result      <= md_res;
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
